// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and instruction-fetch handshake of the PC sequencer.
// master = sequencer side, slave = core/memory environment side.
interface pc_sequencer_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        trap_req;
   logic        mret;
   logic        imem_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic        fetch_valid;
   logic [31:0] mepc;
   logic [1:0]  trap_cause;

   modport master (
      input  stall, branch_taken, branch_target, jump, jump_target,
             trap_req, mret, imem_ready,
      output imem_req, imem_addr, pc, fetch_valid, mepc, trap_cause
   );

   modport slave (
      output stall, branch_taken, branch_target, jump, jump_target,
             trap_req, mret, imem_ready,
      input  imem_req, imem_addr, pc, fetch_valid, mepc, trap_cause
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: BOOT/FETCH/EXEC program-counter sequencer with trap entry and mret.
// Optional macro PC_MISALIGN_TRAP_EN: a misaligned jump/branch target traps with cause 2;
// when undefined the target is loaded with bits[1:0] cleared.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h00000000,
   parameter logic [31:0] TRAP_VECTOR = 32'h00000100
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_mepc;
   logic [1:0]  r_cause;
   logic        r_imem_req;
   logic        r_fetch_valid;

   logic        w_jb_sel;
   logic [31:0] w_target;
   logic [31:0] w_target_al;
   logic        w_misalign;

   // jump outranks branch when both are asserted
   assign w_jb_sel    = bus.jump | bus.branch_taken;
   assign w_target    = bus.jump ? bus.jump_target : bus.branch_target;
   assign w_target_al = w_target & ~32'h00000003;
   assign w_misalign  = (w_target != w_target_al);

   assign bus.pc          = r_pc;
   assign bus.imem_addr   = r_pc;
   assign bus.imem_req    = r_imem_req;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.mepc        = r_mepc;
   assign bus.trap_cause  = r_cause;

   // sequencer FSM with registered handshake outputs and next-PC selection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_PC;
         r_mepc        <= '0;
         r_cause       <= '0;
         r_imem_req    <= 1'b0;
         r_fetch_valid <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state    <= S_FETCH;
               r_imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (bus.imem_ready) begin
                  r_state       <= S_EXEC;
                  r_imem_req    <= 1'b0;
                  r_fetch_valid <= 1'b1;
               end
            end
            S_EXEC: begin
               if (!bus.stall) begin
                  r_state       <= S_FETCH;
                  r_imem_req    <= 1'b1;
                  r_fetch_valid <= 1'b0;
                  if (bus.trap_req) begin
                     r_mepc  <= r_pc;
                     r_pc    <= TRAP_VECTOR;
                     r_cause <= 2'd1;
                  end else if (bus.mret) begin
                     r_pc    <= r_mepc;
                     r_cause <= 2'd0;
                  end else if (w_jb_sel) begin
`ifdef PC_MISALIGN_TRAP_EN
                     if (w_misalign) begin
                        r_mepc  <= r_pc;
                        r_pc    <= TRAP_VECTOR;
                        r_cause <= 2'd2;
                     end else begin
                        r_pc <= w_target_al;
                     end
`else
                     r_pc <= w_target_al;
`endif
                  end else begin
                     r_pc <= r_pc + 32'd4;
                  end
               end
            end
            default: begin
               r_state       <= S_BOOT;
               r_imem_req    <= 1'b0;
               r_fetch_valid <= 1'b0;
            end
         endcase
      end
   end

`ifndef PC_MISALIGN_TRAP_EN
   // misalignment is only acted on when trapping is enabled
   logic w_unused_misalign;
   assign w_unused_misalign = w_misalign;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a PC scoreboard queue.
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pc_sequencer_if bus();

   pc_sequencer #(.RESET_PC(32'h00000000), .TRAP_VECTOR(32'h00000100)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic push_pc(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic pop_pc();
      exp_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
      end else begin
         e = sb.pop_front();
         chk(e.tag, bus.pc, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      bus.jump          = 1'b0;
      bus.jump_target   = '0;
      bus.trap_req      = 1'b0;
      bus.mret          = 1'b0;
   endtask

   // one EXEC retire with the given controls, then the 1-cycle refetch (imem_ready=1)
   task automatic step(input string tag, input logic jmp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic trp,
                       input logic mrt, input logic [31:0] exp_pc);
      chk({tag, "_in_exec"}, {31'b0, bus.fetch_valid}, 32'd1);
      bus.jump          = jmp;
      bus.jump_target   = jt;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.trap_req      = trp;
      bus.mret          = mrt;
      push_pc(tag, exp_pc);
      tick();
      clear_ctl();
      pop_pc();
      chk({tag, "_req"}, {31'b0, bus.imem_req}, 32'd1);
      chk({tag, "_addr"}, bus.imem_addr, exp_pc);
      tick();
   endtask

   initial begin
      bit seen;
      clear_ctl();
      bus.imem_ready = 1'b0;

      // reset state
      #12;
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_fv", {31'b0, bus.fetch_valid}, 32'd0);
      chk("rst_mepc", bus.mepc, 32'h0);
      chk("rst_cause", {30'b0, bus.trap_cause}, 32'd0);

      // release with imem_ready tied high: pc 0,4,8 with fetch_valid every other cycle
      @(negedge clk);
      reset = 1'b1;
      bus.imem_ready = 1'b1;
      push_pc("seq_pc0", 32'h0);
      push_pc("seq_pc4", 32'h4);
      push_pc("seq_pc8", 32'h8);
      tick();
      chk("boot_req", {31'b0, bus.imem_req}, 32'd1);
      chk("boot_fv", {31'b0, bus.fetch_valid}, 32'd0);
      chk("boot_addr", bus.imem_addr, 32'h0);
      tick();
      chk("seq_fv0", {31'b0, bus.fetch_valid}, 32'd1);
      chk("seq_req0", {31'b0, bus.imem_req}, 32'd0);
      pop_pc();
      tick();
      chk("seq_fv_lo", {31'b0, bus.fetch_valid}, 32'd0);
      tick();
      chk("seq_fv1", {31'b0, bus.fetch_valid}, 32'd1);
      pop_pc();
      tick();
      tick();
      chk("seq_fv2", {31'b0, bus.fetch_valid}, 32'd1);
      pop_pc();

      // control priority and trap/mret
      step("jump_10", 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h10);
      step("jump_over_br", 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h40);
      step("branch_20", 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h20);
      step("trap", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
      chk("trap_mepc", bus.mepc, 32'h20);
      chk("trap_cause", {30'b0, bus.trap_cause}, 32'd1);
      step("seq_104", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h104);
      chk("cause_hold", {30'b0, bus.trap_cause}, 32'd1);
      step("mret", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
      chk("mret_cause", {30'b0, bus.trap_cause}, 32'd0);
      chk("mret_mepc", bus.mepc, 32'h20);
      step("trap_vs_mret", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
      chk("tvm_cause", {30'b0, bus.trap_cause}, 32'd1);
      step("mret2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);

      // stall for 3 EXEC cycles with a pending branch
      bus.stall = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 32'h60;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", bus.pc, 32'h20);
         chk("stall_fv", {31'b0, bus.fetch_valid}, 32'd1);
      end
      bus.stall = 1'b0;
      push_pc("stall_release", 32'h60);
      tick();
      clear_ctl();
      pop_pc();
      tick();

      // misaligned targets
`ifdef PC_MISALIGN_TRAP_EN
      step("mis_jump", 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100);
      chk("mis_cause", {30'b0, bus.trap_cause}, 32'd2);
      chk("mis_mepc", bus.mepc, 32'h60);
      step("mis_branch", 1'b0, 32'h0, 1'b1, 32'h83, 1'b0, 1'b0, 32'h100);
      chk("misb_mepc", bus.mepc, 32'h100);
`else
      step("mis_jump", 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40);
      chk("mis_cause", {30'b0, bus.trap_cause}, 32'd0);
      chk("mis_mepc", bus.mepc, 32'h20);
      step("mis_branch", 1'b0, 32'h0, 1'b1, 32'h83, 1'b0, 1'b0, 32'h80);
`endif

      // pc+4 wrap
      step("to_top", 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFC);
      step("wrap", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

      // fetch stall with ignored controls, then async reset mid-wait
      bus.imem_ready = 1'b0;
      push_pc("to_fetch", 32'h4);
      tick();
      pop_pc();
      bus.jump = 1'b1;
      bus.jump_target = 32'h200;
      bus.trap_req = 1'b1;
      bus.mret = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_req", {31'b0, bus.imem_req}, 32'd1);
         chk("wait_addr", bus.imem_addr, 32'h4);
         chk("wait_fv", {31'b0, bus.fetch_valid}, 32'd0);
      end
      clear_ctl();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_req", {31'b0, bus.imem_req}, 32'd0);
      chk("arst_pc", bus.pc, 32'h0);
      chk("arst_mepc", bus.mepc, 32'h0);
      chk("arst_cause", {30'b0, bus.trap_cause}, 32'd0);

      // restart after reset, bounded wait for the first fetched instruction
      @(negedge clk);
      reset = 1'b1;
      bus.imem_ready = 1'b1;
      push_pc("restart_pc", 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         if (bus.fetch_valid === 1'b1) seen = 1'b1;
      end
      if (seen) pop_pc();
      else chk("restart_timeout", {31'b0, bus.fetch_valid}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h00000100, PC value loaded on trap entry.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  holds the current instruction in EXEC.
REQ-006 branch_taken  input  1  conditional branch resolved taken.
REQ-007 branch_target  input  32  branch destination.
REQ-008 jump  input  1  unconditional jump (JAL/JALR).
REQ-009 jump_target  input  32  jump destination.
REQ-010 trap_req  input  1  ecall or illegal instruction detected.
REQ-011 mret  input  1  return from trap.
REQ-012 imem_ready  input  1  instruction memory accepted the request and data is available.
REQ-013 imem_req  output  1  fetch request.
REQ-014 imem_addr  output  32  fetch address, equal to pc.
REQ-015 pc  output  32  current PC.
REQ-016 fetch_valid  output  1  the fetched instruction is valid for execution.
REQ-017 mepc  output  32  saved exception PC.
REQ-018 trap_cause  output  2  cause code: 0 none, 1 trap request, 2 misaligned target.

Function
REQ-019 States SHALL be BOOT, FETCH and EXEC.
REQ-020 BOOT: outputs idle; SHALL go to FETCH on the first clock after reset release.
REQ-021 FETCH SHALL drive imem_req=1 and imem_addr=pc, and SHALL hold them stable until imem_ready=1.
REQ-022 In FETCH, imem_ready=1 SHALL move the block to EXEC on the next edge; the minimum fetch latency is 1 cycle.
REQ-023 EXEC SHALL drive fetch_valid=1 and imem_req=0.
REQ-024 EXEC with stall=1 SHALL hold pc and state, and SHALL ignore all control inputs.
REQ-025 EXEC with stall=0 SHALL update pc and return to FETCH.
REQ-026 Next-PC priority SHALL be: trap_req, then mret, then jump, then branch_taken, else pc+4.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-028 trap_req SHALL load mepc with pc, load pc with TRAP_VECTOR and set trap_cause to 1.
REQ-029 mret SHALL load pc with mepc and clear trap_cause to 0; mepc is unchanged.
REQ-030 trap_cause SHALL hold its value until the next trap or mret.
REQ-031 Control inputs SHALL be ignored outside EXEC.
REQ-032 Simultaneous trap_req and mret SHALL take the trap.

Reset
REQ-033 Reset assertion SHALL immediately force: pc=RESET_PC, mepc=0, trap_cause=0, imem_req=0, fetch_valid=0, state BOOT.
REQ-034 Reset asserted during FETCH SHALL abandon the outstanding request without waiting for imem_ready.

Configuration
REQ-035 Macro PC_MISALIGN_TRAP_EN controls misaligned-target checking.
REQ-036 With PC_MISALIGN_TRAP_EN defined, a selected jump or branch target with bits[1:0]!=0 SHALL be treated as a trap:
- mepc <= pc
- pc <= TRAP_VECTOR
- trap_cause <= 2
REQ-037 Without PC_MISALIGN_TRAP_EN, a selected target SHALL be loaded with bits[1:0] forced to 0, and trap_cause SHALL be unaffected.

Verification
REQ-038 Reset release, imem_ready tied 1 -> pc sequence 0,4,8; fetch_valid high every second cycle starting 2 cycles after release.
REQ-039 pc=0x10, jump=1, jump_target=0x40, branch_taken=1, branch_target=0x80 -> next pc=0x40.
REQ-040 pc=0x20, trap_req=1 -> pc=0x100, mepc=0x20, trap_cause=1; then mret -> pc=0x20, trap_cause=0.
REQ-041 stall=1 for 3 EXEC cycles with branch_taken=1 -> pc unchanged, fetch_valid held 1; branch taken after stall drops.
REQ-042 imem_ready held 0 for 5 cycles -> imem_req=1 and imem_addr stable throughout; reset pulse mid-wait -> imem_req=0 and pc=0 asynchronously.
REQ-043 Macro defined, jump_target=0x42 -> pc=0x100, trap_cause=2; macro undefined -> pc=0x40.
